// File: rtl/counter_arbiter.sv
// counter_arbiter: two-requester arbiter/sequencer owning one shared up-counter's reset and enable.
// Latency: grant one edge after the request is sampled; done pulses len+2 edges after that sample.
// Optional COUNTER_ARB_ROUND_ROBIN_EN enables the round-robin pointer; without it, requester 0 has fixed priority.
module counter_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic             grant0,
  output logic             grant1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             cnt_reset,
  output logic             cnt_enable,
  input  logic [WIDTH-1:0] cnt_value
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic             owner;   // 0 = requester 0, 1 = requester 1
  logic [WIDTH-1:0] len_q;   // run length captured at grant time
  logic             pick;    // winner if arbitration happens this cycle

`ifdef COUNTER_ARB_ROUND_ROBIN_EN
  logic ptr;                 // preferred requester when both ask

  // Winner: the lone requester, or the preferred one when both ask
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = ptr;
    else              pick = req1;
  end

  // After each completed run, prefer the requester that did not just own the counter
  always_ff @(posedge clock) begin
    if (reset)              ptr <= 1'b0;
    else if (state == DONE) ptr <= ~owner;
  end
`else
  // Fixed priority: requester 0 wins whenever it is asking
  always_comb begin
    pick = 1'b0;
    if (!req0) pick = 1'b1;
  end
`endif

  // Sequencer: clear the counter, run until it reaches len_q, then signal completion
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state <= CLEAR;
            owner <= pick;
            len_q <= pick ? len1 : len0;
          end
        end
        CLEAR:   state <= RUN;
        RUN:     if (cnt_value == len_q) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The counter is held clear in the CLEAR cycle, so it can never run past len_q
  assign cnt_reset  = reset || (state == CLEAR);
  assign cnt_enable = !reset && (state == RUN) && (cnt_value != len_q);
  assign busy       = (state != IDLE);
  assign grant0     = busy && !owner;
  assign grant1     = busy &&  owner;
  assign done0      = (state == DONE) && !owner;
  assign done1      = (state == DONE) &&  owner;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter with a behavioural model of the shared up-counter.
// Table of single-run vectors plus hand sequences for reset, back-to-back and mid-run reset.
// Expected grant order follows COUNTER_ARB_ROUND_ROBIN_EN when it is defined.
module tb_counter_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [3:0] len0, len1;
  logic       grant0, grant1, done0, done1, busy, cnt_reset, cnt_enable;
  logic [3:0] cnt_value;

  int checks   = 0;
  int failures = 0;

  counter_arbiter #(.WIDTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .len0       (len0),
    .len1       (len1),
    .grant0     (grant0),
    .grant1     (grant1),
    .done0      (done0),
    .done1      (done1),
    .busy       (busy),
    .cnt_reset  (cnt_reset),
    .cnt_enable (cnt_enable),
    .cnt_value  (cnt_value)
  );

  always #5 clock = ~clock;

  // Shared up-counter model
  always_ff @(posedge clock) begin
    if (cnt_reset)       cnt_value <= 4'd0;
    else if (cnt_enable) cnt_value <= cnt_value + 4'd1;
  end

  typedef struct {
    logic       r0;
    logic       r1;
    logic [3:0] l0;
    logic [3:0] l1;
    logic [3:0] l0_after;  // len0 value driven after the grant
    int         exp_owner;
    int         exp_len;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Apply one request set from IDLE and measure the whole run cycle by cycle
  task automatic run_vec(input vec_t v, input string tag);
    int g_own = 0, g_oth = 0, en = 0, rs = 0, d_own = 0, d_oth = 0, d_k = -1, bz = 0;
    int fin = -1;
    bit ended = 0;
    @(negedge clock);
    req0 = v.r0; req1 = v.r1; len0 = v.l0; len1 = v.l1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (k == 0) len0 = v.l0_after;
      if (v.exp_owner == 0) begin
        g_own += int'(grant0); g_oth += int'(grant1);
        d_own += int'(done0);  d_oth += int'(done1);
      end else begin
        g_own += int'(grant1); g_oth += int'(grant0);
        d_own += int'(done1);  d_oth += int'(done0);
      end
      en += int'(cnt_enable);
      rs += int'(cnt_reset);
      bz += int'(busy);
      if (done0 || done1) begin
        d_k = k;
        req0 = 1'b0; req1 = 1'b0;
      end
      if (!busy) begin
        fin = int'(cnt_value);
        ended = 1;
        break;
      end
    end
    if (!ended) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_grant_owner"}, g_own, v.exp_len + 3);
    chk({tag, "_grant_other"}, g_oth, 0);
    chk({tag, "_enables"},     en,    v.exp_len);
    chk({tag, "_cnt_reset"},   rs,    1);
    chk({tag, "_done_owner"},  d_own, 1);
    chk({tag, "_done_other"},  d_oth, 0);
    chk({tag, "_done_cycle"},  d_k,   v.exp_len + 2);
    chk({tag, "_busy"},        bz,    v.exp_len + 3);
    chk({tag, "_final_cnt"},   fin,   v.exp_len);
  endtask

  initial begin
    int order[4];
    int exp_order[4];
    int n, gap;
    bit prev_g, seen3;
    vec_t v;

    vecs[0] = '{r0:1'b1, r1:1'b0, l0:4'd5,  l1:4'd0, l0_after:4'd5,  exp_owner:0, exp_len:5};
    vecs[1] = '{r0:1'b0, r1:1'b1, l0:4'd0,  l1:4'd0, l0_after:4'd0,  exp_owner:1, exp_len:0};
    vecs[2] = '{r0:1'b1, r1:1'b0, l0:4'd15, l1:4'd0, l0_after:4'd15, exp_owner:0, exp_len:15};
    vecs[3] = '{r0:1'b0, r1:1'b1, l0:4'd0,  l1:4'd1, l0_after:4'd0,  exp_owner:1, exp_len:1};
    vecs[4] = '{r0:1'b1, r1:1'b1, l0:4'd3,  l1:4'd7, l0_after:4'd3,  exp_owner:0, exp_len:3};
`ifdef COUNTER_ARB_ROUND_ROBIN_EN
    vecs[5] = '{r0:1'b1, r1:1'b1, l0:4'd2,  l1:4'd4, l0_after:4'd2,  exp_owner:1, exp_len:4};
    exp_order = '{0, 1, 0, 1};
`else
    vecs[5] = '{r0:1'b1, r1:1'b1, l0:4'd2,  l1:4'd4, l0_after:4'd2,  exp_owner:0, exp_len:2};
    exp_order = '{0, 0, 0, 0};
`endif
    vecs[6] = '{r0:1'b1, r1:1'b0, l0:4'd4,  l1:4'd0, l0_after:4'd9,  exp_owner:0, exp_len:4};
    vecs[7] = '{r0:1'b0, r1:1'b1, l0:4'd0,  l1:4'd2, l0_after:4'd0,  exp_owner:1, exp_len:2};

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = 4'd0; len1 = 4'd0;

    // Reset held three cycles
    step(); step(); step();
    chk("rst_grant0", grant0, 0);
    chk("rst_grant1", grant1, 0);
    chk("rst_done",   {done0, done1}, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_cnt_reset",  cnt_reset, 1);
    chk("rst_cnt_enable", cnt_enable, 0);
    chk("rst_cnt_value",  cnt_value, 0);
    reset = 1'b0;
    step();
    chk("post_rst_cnt_reset", cnt_reset, 0);
    chk("post_rst_busy", busy, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Both requesters held across several runs
    @(negedge clock);
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd3;
    n = 0; gap = 0; prev_g = 0; seen3 = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if ((grant0 || grant1) && !prev_g) begin
        if (n < 4) order[n] = int'(grant1);
        if (n > 0 && n < 4) chk($sformatf("b2b_gap%0d", n), gap, 1);
        n++;
        gap = 0;
      end
      if (!(grant0 || grant1)) gap++;
      prev_g = grant0 || grant1;
      if ((done0 || done1) && n >= 4) begin
        req0 = 1'b0; req1 = 1'b0; seen3 = 1;
      end
      if (seen3 && !busy) break;
    end
    chk("b2b_grants", n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_order%0d", i), order[i], exp_order[i]);
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Move the round-robin pointer to requester 1, then reset mid-run
    v = '{r0:1'b1, r1:1'b0, l0:4'd1, l1:4'd0, l0_after:4'd1, exp_owner:0, exp_len:1};
    run_vec(v, "pre_rst");
    @(negedge clock);
    req0 = 1'b1; len0 = 4'd9;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (busy && cnt_value == 4'd3) begin n = 1; break; end
    end
    chk("mid_reached3", n, 1);
    reset = 1'b1; req0 = 1'b0;
    step();
    chk("mid_grant0", grant0, 0);
    chk("mid_grant1", grant1, 0);
    chk("mid_done",   {done0, done1}, 0);
    chk("mid_busy",   busy, 0);
    chk("mid_cnt_reset",  cnt_reset, 1);
    chk("mid_cnt_enable", cnt_enable, 0);
    reset = 1'b0;
    step();
    chk("mid_cnt_value", cnt_value, 0);
    chk("mid_busy_after", busy, 0);

    // Pointer must be back at requester 0 after reset
    v = '{r0:1'b1, r1:1'b1, l0:4'd2, l1:4'd6, l0_after:4'd2, exp_owner:0, exp_len:2};
    run_vec(v, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Two-requester arbiter and sequencer for the team's shared up-counter, which has ports clock, reset, enable and counter_out. Each requester asks for a run of N enabled counter cycles. The arbiter picks one requester, clears the counter, and enables it for exactly N cycles. It then pulses done to the winner and frees the counter. It sits between the requesting control blocks and one counter instance, and owns that counter's reset and enable.

## Interface
- WIDTH, 4, width of the counter value and of the requested run lengths.

- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0, req1  input  1 each  request lines.
  - Held high, with len stable, until the matching done pulse.
- len0, len1  input  WIDTH each  requested number of enabled cycles, 0..2^WIDTH-1.
- grant0, grant1  output  1 each  requester currently owns the counter; one-hot or zero.
- done0, done1  output  1 each  one-cycle pulse when the owner's run completes.
- busy  output  1  arbiter is not IDLE.
- cnt_reset  output  1  drives the counter's reset.
- cnt_enable  output  1  drives the counter's enable.
- cnt_value  input  WIDTH  counter_out of the shared counter.

## Operation
- States:
  - IDLE: no owner.
  - CLEAR: clear the counter.
  - RUN: count until the target is reached.
  - DONE: signal completion.
- IDLE → CLEAR when any req is high at the edge.
  - Winner is chosen by the priority pointer.
  - The winner's len is latched into len_q.
  - The winner is recorded as owner.
- CLEAR → RUN unconditionally.
- RUN → DONE at the edge where cnt_value == len_q.
- DONE → IDLE unconditionally.
- Priority pointer:
  - Round-robin: after a grant completes, the other requester is preferred next.
  - Reset value: requester 0 preferred.
  - With only one req high, that requester wins regardless of the pointer.
- Combinational outputs:
  - cnt_reset = reset OR state==CLEAR.
  - cnt_enable = state==RUN AND cnt_value != len_q.
  - grant_k = owner==k AND state in {CLEAR, RUN, DONE}.
  - done_k = owner==k AND state==DONE.
  - busy = state != IDLE.
- len_q is captured only on the IDLE → CLEAR transition. Changes to len after the grant are ignored.
- len = 0: RUN lasts one cycle with cnt_enable low. The counter never advances.
- No wrap: the counter never passes len_q because it is cleared in CLEAR first. Maximum len (15 at WIDTH=4) yields 15 enabled cycles.
- A requester still high in the cycle after its done re-requests. It is arbitrated normally in IDLE, so round-robin favours the other requester if it is pending.
- Dropping req while granted has no effect. The run completes and done still pulses.
- Reset, at any time including mid-RUN:
  - Next state is IDLE; owner and pointer return to requester 0.
  - All grant, done and busy outputs are 0.
  - cnt_reset is high for the reset cycle(s) and cnt_enable is low.

## Timing
- Request sampled at edge E. grant is high from E+1 through E+len+3.
- CLEAR occupies cycle E..E+1 with cnt_reset high. The counter reads 0 at edge E+1.
- RUN lasts len+1 cycles, of which cnt_enable is high for exactly len cycles.
- done is high for one cycle between edges E+len+2 and E+len+3.
- busy deasserts at E+len+3.
- Back-to-back runs: minimum gap between grants is one IDLE cycle. Per-run overhead is 4 cycles beyond len.

## Configuration
- COUNTER_ARB_ROUND_ROBIN_EN defined: round-robin pointer as above.
- Undefined: fixed priority, with requester 0 always winning simultaneous requests. The pointer register is not built.
- All other behaviour is identical in both builds.

## Test plan
- Reset held 3 cycles, then req0=1 with len0=5: cnt_reset high for 1 cycle, then cnt_enable high exactly 5 cycles. cnt_value ends at 5, done0 pulses once at E+7, grant1 stays 0.
- req0 and req1 both high with len0=2 and len1=3, held after done:
  - With COUNTER_ARB_ROUND_ROBIN_EN the grant order is 0, 1, 0, 1.
  - Without it, requester 0 is granted every time.
- req1=1 with len1=0: grant1 high for 3 cycles, cnt_enable never high, cnt_value stays 0, done1 pulses.
- req0=1 with len0=15: 15 enabled cycles, cnt_value reaches 15 with no wrap to 0, done0 pulses once.
- Reset asserted mid-RUN with cnt_value=3 and len0=9: at the next edge state is IDLE and all grant, done and busy outputs are 0. cnt_reset is high during reset and cnt_value reads 0 afterwards.
- len0 changed from 4 to 9 after the grant: the run still completes after 4 enabled cycles.
